// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port 32-bit data memory with grant/rvalid handshake, 1-cycle read latency.
// Optional grant wait states via DMEM_WAIT_STATES_EN (latency WAIT_CYCLES); default build grants immediately.
`default_nettype none

module data_mem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic                  data_wr_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [31:0]           data_wdata_i,
  input  logic [3:0]            data_be_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o
);

  localparam int WORD_BITS = ADDR_WIDTH - 2;
  localparam int DEPTH     = 1 << WORD_BITS;

`ifdef DMEM_WAIT_STATES_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1
  } state_t;
`endif

  state_t                state;
  state_t                state_next;
  logic                  gnt;
  logic [WORD_BITS-1:0]  word_idx;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           rdata;
  logic                  unused_addr_lsbs;

  // Sub-word address bits are deliberately ignored: no alignment checking.
  assign word_idx         = data_addr_i[ADDR_WIDTH-1:2];
  assign unused_addr_lsbs = &{1'b0, data_addr_i[1:0]};

`ifdef DMEM_WAIT_STATES_EN
  logic [3:0] wait_cnt;
  logic       cnt_load;
  logic       cnt_dec;

  always_comb begin
    state_next = state;
    gnt        = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (data_req_i) begin
          state_next = WAIT;
          cnt_load   = 1'b1;
        end
      end
      RESP: begin
        if (data_req_i) begin
          state_next = WAIT;
          cnt_load   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        // A dropped request abandons the access without touching memory.
        if (!data_req_i) begin
          state_next = IDLE;
        end else if (wait_cnt == 4'd0) begin
          gnt        = rst_n;
          state_next = data_wr_i ? IDLE : RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (cnt_load) begin
      wait_cnt <= 4'(WAIT_CYCLES - 1);
    end else if (cnt_dec) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;

  // Zero-wait build: every request is accepted on sight in IDLE and RESP.
  always_comb begin
    state_next = IDLE;
    gnt        = rst_n & data_req_i;
    if (gnt && !data_wr_i) begin
      state_next = RESP;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory array has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (gnt && data_wr_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'h0;
    end else if (gnt && !data_wr_i) begin
      rdata <= mem[word_idx];
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = (state == RESP);
  assign data_rdata_o  = rdata;

endmodule

`default_nettype wire
